// File: rtl/div_result_fifo.sv
// Result buffer behind the 8-bit combinational divider.
// Entries {quotient, remainder, dbz} go through a DEPTH-entry FIFO with valid/ready on both sides.
module div_result_fifo #(
    parameter int DEPTH = 4,
    parameter int QW    = 8,
    parameter int RW    = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [QW-1:0]            quotient_i,
    input  logic [RW-1:0]            remainder_i,
    input  logic [3:0]               divisor_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [QW-1:0]            quotient_o,
    output logic [RW-1:0]            remainder_o,
    output logic                     dbz_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [7:0]               dbz_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [7:0]    dbz_cnt_reg, dbz_cnt_next;

    logic [QW-1:0] q_mem   [DEPTH];
    logic [RW-1:0] r_mem   [DEPTH];
    logic          dbz_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          in_dbz;
    logic [QW-1:0] wr_q;
    logic [RW-1:0] wr_r;

    // Flags come from the registered count only, so out_ready_i never reaches in_ready_o.
    assign in_ready_o  = (count_reg != CW'(DEPTH));
    assign out_valid_o = (count_reg != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // A zero divisor leaves the divider outputs undefined; store all-ones sentinels instead.
    assign in_dbz = (divisor_i == 4'd0);
    assign wr_q   = in_dbz ? '1 : quotient_i;
    assign wr_r   = in_dbz ? '1 : remainder_i;

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        dbz_cnt_next = dbz_cnt_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        if (push && in_dbz && (dbz_cnt_reg != 8'hFF)) begin
            dbz_cnt_next = dbz_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            dbz_cnt_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            dbz_cnt_reg <= dbz_cnt_next;
        end
    end

    // Storage has no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            q_mem[wr_ptr_reg]   <= wr_q;
            r_mem[wr_ptr_reg]   <= wr_r;
            dbz_mem[wr_ptr_reg] <= in_dbz;
        end
    end

    always_comb begin
        quotient_o  = '0;
        remainder_o = '0;
        dbz_o       = 1'b0;
        if (out_valid_o) begin
            quotient_o  = q_mem[rd_ptr_reg];
            remainder_o = r_mem[rd_ptr_reg];
            dbz_o       = dbz_mem[rd_ptr_reg];
        end
    end

    assign count_o   = count_reg;
    assign dbz_cnt_o = dbz_cnt_reg;

endmodule
